// File: rtl/uart_rx_stream.sv
// uart_rx_stream: UART byte receiver feeding a FIFO; 8N1 by default, 8E1 when VT_UART_PARITY_EN is defined.
// Latency: with an empty FIFO and the gap expired, dataReady comes 2 cycles after the cycle that samples the stop bit.
// No back-pressure: strobes are at least MIN_GAP cycles apart; a byte that reaches a full FIFO is dropped with an overflow pulse.
module uart_rx_stream #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int MIN_GAP    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       dataReady,
  output logic       overflow,
`ifdef VT_UART_PARITY_EN
  output logic       parityError,
`endif
  output logic       frameError
);

  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int GW  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  logic          rx_meta, rx_sync;
  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          bit_end, stop_hit, byte_ok, push;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // 16x oversample strobe; the divider is parked at zero between frames so every frame starts phase-aligned
  assign tick = (state != IDLE) && (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         div_cnt <= '0;
    else if (state == IDLE || tick)   div_cnt <= '0;
    else                              div_cnt <= div_cnt + DW'(1);
  end

  assign bit_end  = tick && (tick_cnt == 4'd15);
  assign stop_hit = (state == STOP) && bit_end;

`ifdef VT_UART_PARITY_EN
  logic par_bit, par_bad;
  assign par_bad = ^{shreg, par_bit};
  assign byte_ok = rx_sync && !par_bad;
`else
  assign byte_ok = rx_sync;
`endif
  assign push = stop_hit && byte_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      frameError <= 1'b0;
`ifdef VT_UART_PARITY_EN
      par_bit     <= 1'b0;
      parityError <= 1'b0;
`endif
    end else begin
      frameError <= 1'b0;
`ifdef VT_UART_PARITY_EN
      parityError <= 1'b0;
`endif
      if (tick) tick_cnt <= tick_cnt + 4'd1;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          // mid-start-bit check; a high level here was only a glitch
          if (tick && tick_cnt == 4'd7) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef VT_UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef VT_UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            par_bit <= rx_sync;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            frameError <= !rx_sync;
`ifdef VT_UART_PARITY_EN
            parityError <= par_bad;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap;
  logic          pop, full, wr_en;

  assign pop   = (count != '0) && (gap == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      gap       <= '0;
      data      <= 8'h00;
      dataReady <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow  <= push && full && !pop;
      dataReady <= pop;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        data   <= mem[rd_ptr];
        gap    <= GW'(MIN_GAP - 1);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Bench for uart_rx_stream: two instances (MIN_GAP 8 and 400) share one rx line; an event-level
// FIFO/pacing model predicts strobes, overflows and error pulses from the frames that were sent.
module tb_uart_rx_stream;

  localparam int DEPTH = 4;
  localparam int GAP_A = 8;
  localparam int GAP_B = 400;
`ifdef VT_UART_PARITY_EN
  localparam bit PAR_EN   = 1'b1;
  localparam int STOP_OFS = 170;
`else
  localparam bit PAR_EN   = 1'b0;
  // 2 sync flops + 1 cycle leaving IDLE + 7 more ticks to mid-start, then 16 per bit for 8 data bits and the stop bit
  localparam int STOP_OFS = 154;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data1, data2;
  logic       dr1, dr2, ovf1, ovf2, fe1, fe2;
`ifdef VT_UART_PARITY_EN
  logic       pe1, pe2;
`endif

  uart_rx_stream #(.CLK_FREQ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP_A)) dut_a (
    .clk(clk), .rst(rst), .rx(rx), .data(data1), .dataReady(dr1), .overflow(ovf1),
`ifdef VT_UART_PARITY_EN
    .parityError(pe1),
`endif
    .frameError(fe1));

  uart_rx_stream #(.CLK_FREQ(1_600_000), .BAUD(100_000), .FIFO_DEPTH(DEPTH), .MIN_GAP(GAP_B)) dut_b (
    .clk(clk), .rst(rst), .rx(rx), .data(data2), .dataReady(dr2), .overflow(ovf2),
`ifdef VT_UART_PARITY_EN
    .parityError(pe2),
`endif
    .frameError(fe2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // observed events, per instance
  int c1_d[$], c1_c[$], c2_d[$], c2_c[$];
  int o1 = 0, o2 = 0, f1 = 0, f2 = 0, p1 = 0, p2 = 0;

  always @(negedge clk) begin
    if (dr1) begin c1_d.push_back(int'(data1)); c1_c.push_back(cyc); end
    if (dr2) begin c2_d.push_back(int'(data2)); c2_c.push_back(cyc); end
    if (ovf1) o1++;
    if (ovf2) o2++;
    if (fe1) f1++;
    if (fe2) f2++;
`ifdef VT_UART_PARITY_EN
    if (pe1) p1++;
    if (pe2) p2++;
`endif
  end

  // frames sent in the current phase
  int fr_b[$], fr_stop[$];
  bit fr_sok[$], fr_pok[$];

  // model predictions
  int ex_d[$], ex_c[$];
  int ex_ovf, ex_ferr, ex_perr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_phase();
    fr_b.delete(); fr_stop.delete(); fr_sok.delete(); fr_pok.delete();
    c1_d.delete(); c1_c.delete(); c2_d.delete(); c2_c.delete();
    o1 = 0; o2 = 0; f1 = 0; f2 = 0; p1 = 0; p2 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx  = 1'b1;
    step(3);
    rst = 1'b1;
    step(3);
    clear_phase();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit sok, input bit pok);
    fr_b.push_back(int'(b));
    fr_sok.push_back(sok);
    fr_pok.push_back(pok);
    fr_stop.push_back(cyc + STOP_OFS);
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(16);
    end
`ifdef VT_UART_PARITY_EN
    rx = (^b) ^ !pok;
    step(16);
`endif
    rx = sok;
    step(16);
    rx = 1'b1;
  endtask

  // Event-level model: each accepted byte is eligible the cycle after its stop sample; it pops at the later of
  // that and the pacing limit, and is seen as a strobe one cycle after the pop.
  task automatic model(input int gap);
    int q_b[$];
    int q_a[$];
    int next_ok;
    int pt;
    bit ok, pop_now;
    ex_d.delete(); ex_c.delete();
    ex_ovf = 0; ex_ferr = 0; ex_perr = 0; next_ok = 0;
    for (int i = 0; i < fr_b.size(); i++) begin
      while (q_b.size() > 0 && ((next_ok > q_a[0]) ? next_ok : q_a[0]) < fr_stop[i]) begin
        pt = (next_ok > q_a[0]) ? next_ok : q_a[0];
        ex_d.push_back(q_b.pop_front());
        void'(q_a.pop_front());
        ex_c.push_back(pt + 1);
        next_ok = pt + gap;
      end
      if (!fr_sok[i]) ex_ferr++;
      if (PAR_EN && !fr_pok[i]) ex_perr++;
      ok = fr_sok[i] && (fr_pok[i] || !PAR_EN);
      if (ok) begin
        pop_now = (q_b.size() > 0) && (((next_ok > q_a[0]) ? next_ok : q_a[0]) == fr_stop[i]);
        if (q_b.size() < DEPTH || pop_now) begin
          q_b.push_back(fr_b[i]);
          q_a.push_back(fr_stop[i] + 1);
        end else begin
          ex_ovf++;
        end
      end
    end
    while (q_b.size() > 0) begin
      pt = (next_ok > q_a[0]) ? next_ok : q_a[0];
      ex_d.push_back(q_b.pop_front());
      void'(q_a.pop_front());
      ex_c.push_back(pt + 1);
      next_ok = pt + gap;
    end
  endtask

  task automatic check_phase(input int which, input string tag);
    int cd[$], cc[$];
    int co, cf, cp;
    if (which == 0) begin cd = c1_d; cc = c1_c; co = o1; cf = f1; cp = p1; model(GAP_A); end
    else            begin cd = c2_d; cc = c2_c; co = o2; cf = f2; cp = p2; model(GAP_B); end
    chk($sformatf("%s[%0d] strobe count", tag, which), cd.size(), ex_d.size());
    for (int i = 0; i < ex_d.size() && i < cd.size(); i++) begin
      chk($sformatf("%s[%0d] byte %0d data", tag, which, i), cd[i], ex_d[i]);
      chk($sformatf("%s[%0d] byte %0d cycle", tag, which, i), cc[i], ex_c[i]);
    end
    chk($sformatf("%s[%0d] overflow pulses", tag, which), co, ex_ovf);
    chk($sformatf("%s[%0d] frameError pulses", tag, which), cf, ex_ferr);
`ifdef VT_UART_PARITY_EN
    chk($sformatf("%s[%0d] parityError pulses", tag, which), cp, ex_perr);
`else
    if (cp != 0) chk($sformatf("%s[%0d] phantom parity", tag, which), cp, 0);
`endif
  endtask

  typedef struct {
    bit         glitch;
    logic [7:0] b;
    bit         sok;
    int         n_strobe;
    logic [7:0] d;
    int         n_fe;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int k;
    int held;
    logic [7:0] rb;
    bit sok, pok;
    int idl;

    tbl[0] = '{1'b0, 8'h1B, 1'b1, 1, 8'h1B, 0};
    tbl[1] = '{1'b1, 8'h00, 1'b1, 0, 8'h00, 0};
    tbl[2] = '{1'b0, 8'h41, 1'b1, 1, 8'h41, 0};
    tbl[3] = '{1'b0, 8'h55, 1'b0, 0, 8'h00, 1};
    tbl[4] = '{1'b0, 8'hAA, 1'b1, 1, 8'hAA, 0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1, 8'h00, 0};
    tbl[6] = '{1'b0, 8'hFF, 1'b1, 1, 8'hFF, 0};
    tbl[7] = '{1'b0, 8'h80, 1'b0, 0, 8'h00, 1};
    tbl[8] = '{1'b0, 8'h01, 1'b1, 1, 8'h01, 0};

    step(1);
    rst = 1'b0;
    #2;
    chk("reset data a", int'(data1), 0);
    chk("reset dataReady a", int'(dr1), 0);
    chk("reset overflow a", int'(ovf1), 0);
    chk("reset frameError a", int'(fe1), 0);
    chk("reset data b", int'(data2), 0);
    chk("reset dataReady b", int'(dr2), 0);
    chk("reset overflow b", int'(ovf2), 0);
    chk("reset frameError b", int'(fe2), 0);
`ifdef VT_UART_PARITY_EN
    chk("reset parityError a", int'(pe1), 0);
`endif
    do_reset();

    // directed single-frame vectors on the MIN_GAP=8 instance
    held = 0;
    for (int i = 0; i < 9; i++) begin
      clear_phase();
      k = cyc;
      if (tbl[i].glitch) begin
        rx = 1'b0;
        step(1);
        rx = 1'b1;
        step(60);
      end else begin
        send_frame(tbl[i].b, tbl[i].sok, 1'b1);
        step(60);
      end
      chk($sformatf("vec%0d strobes", i), c1_d.size(), tbl[i].n_strobe);
      if (tbl[i].n_strobe > 0 && c1_d.size() > 0) begin
        chk($sformatf("vec%0d data", i), c1_d[0], int'(tbl[i].d));
        chk($sformatf("vec%0d strobe cycle", i), c1_c[0], k + STOP_OFS + 2);
        held = int'(tbl[i].d);
      end
      chk($sformatf("vec%0d frameError", i), f1, tbl[i].n_fe);
      chk($sformatf("vec%0d data held", i), int'(data1), held);
    end

    // "[2J" back to back
    do_reset();
    send_frame(8'h5B, 1'b1, 1'b1);
    send_frame(8'h32, 1'b1, 1'b1);
    send_frame(8'h4A, 1'b1, 1'b1);
    step(1800);
    check_phase(0, "esc");
    check_phase(1, "esc");

    // burst into the slow-paced instance: the 8th byte finds its FIFO full
    clear_phase();
    for (int i = 0; i < 8; i++) send_frame(8'h30 + 8'(i), 1'b1, 1'b1);
    step(1800);
    check_phase(0, "burst");
    check_phase(1, "burst");

    // reset mid-DATA while the slow instance still holds two bytes
    do_reset();
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    send_frame(8'h33, 1'b1, 1'b1);
    rx = 1'b0;
    step(16);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      step(16);
    end
    chk("pre-reset data b", int'(data2), 8'h11);
    rst = 1'b0;
    #1;
    chk("midreset data a", int'(data1), 0);
    chk("midreset data b", int'(data2), 0);
    chk("midreset dataReady b", int'(dr2), 0);
    chk("midreset overflow b", int'(ovf2), 0);
    chk("midreset frameError b", int'(fe2), 0);
    rx = 1'b1;
    step(4);
    rst = 1'b1;
    clear_phase();
    step(900);
    chk("post-reset strobes a", c1_d.size(), 0);
    chk("post-reset strobes b", c2_d.size(), 0);
    chk("post-reset errors", f1 + f2 + o1 + o2, 0);
    clear_phase();
    send_frame(8'h7E, 1'b1, 1'b1);
    step(100);
    check_phase(0, "after-rst");
    check_phase(1, "after-rst");

`ifdef VT_UART_PARITY_EN
    clear_phase();
    send_frame(8'h07, 1'b1, 1'b0);
    step(30);
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0);
    step(100);
    check_phase(0, "parity");
    check_phase(1, "parity");
`endif

    // randomized traffic with good and bad frames
    do_reset();
    for (int i = 0; i < 24; i++) begin
      rb  = 8'($urandom);
      sok = ($urandom_range(0, 4) != 0);
      pok = PAR_EN ? ($urandom_range(0, 5) != 0) : 1'b1;
      send_frame(rb, sok, pok);
      idl = sok ? $urandom_range(0, 12) : $urandom_range(20, 30);
      step(idl);
    end
    step(1800);
    check_phase(0, "random");
    check_phase(1, "random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
